flag_cond_unit: RTL and testbench
=================================

Name: flag_cond_unit

Overview:
- Consumer end of the ALU flag interface in the 5-stage pipeline.
- Latches the ALU negative/zero/carry_out/overflow outputs into the architectural NZCV register on flag-setting EX instructions (ADDS/SUBS/ANDS).
- Evaluates B.cond condition codes for the ID stage against those flags.
- Counts taken conditional branches.

Parameters:
- CNT_W, 16: width of the saturating taken-branch counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- ex_valid  input  1  EX stage holds a valid instruction
- ex_set_flags  input  1  EX instruction writes NZCV
- negative  input  1  ALU negative flag (from EX)
- zero  input  1  ALU zero flag
- carry_out  input  1  ALU carry_out
- overflow  input  1  ALU overflow
- stall  input  1  pipeline stall; freeze all state
- flush  input  1  squash ID and EX this cycle
- cond_valid  input  1  ID presents a B.cond request
- cond  input  4  A64 condition code
- flags_q  output  4  architectural flags {N,Z,C,V}
- cond_resolved  output  1  registered: request resolved this cycle
- cond_taken  output  1  registered: branch taken, qualified by cond_resolved
- cond_stall  output  1  combinational: request not accepted, hold ID
- taken_cnt  output  CNT_W  saturating count of taken B.cond

Behaviour:
- Reset values (on any edge with reset=1, overriding everything):
  - flags_q=4'b0000, cond_resolved=0, cond_taken=0, taken_cnt=0.
  - FSM in IDLE; cond_stall=0 while reset is high.
- Flag write: flag_wr = ex_valid & ex_set_flags & ~stall & ~flush.
  - When flag_wr, next edge: flags_q <= {negative,zero,carry_out,overflow}.
  - Otherwise flags_q holds. Non-flag-setting instructions never modify flags_q.
- Accept: acc = cond_valid & ~cond_stall & ~stall & ~flush.
- Resolve, latency 1:
  - When acc, next edge: cond_resolved<=1 and cond_taken<=eval(cond,eff).
  - Otherwise cond_resolved<=0 and cond_taken<=0.
- eval() per code:
  - 0 EQ Z; 1 NE !Z
  - 2 HS C; 3 LO !C
  - 4 MI N; 5 PL !N
  - 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !(C&!Z)
  - A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE !(!Z&(N==V))
  - E and F: always 1.
- eff: the flags used by eval(); depends on FLAG_BYPASS_EN (see Optional Feature).
- Counter:
  - When cond_resolved & cond_taken & ~stall, taken_cnt increments.
  - Saturates at all ones; no wrap.
- Stall: flags_q, taken_cnt and FSM hold. cond_resolved is driven 0 next cycle. A pending request stays presented by ID.
- Flush: no flag write and no acceptance that cycle. cond_resolved is 0 next cycle. FSM returns to IDLE.
- Simultaneous flag_wr and acc: the EX instruction is older than the ID instruction, so its flags must govern the branch (bypass or stall; see Optional Feature).

Optional Feature:
- Macro: FLAG_BYPASS_EN.
- Defined:
  - eff = flag_wr ? {negative,zero,carry_out,overflow} : flags_q.
  - cond_stall is tied to 0.
  - FSM unused; it stays in IDLE.
- Undefined:
  - eff = flags_q.
  - cond_stall = cond_valid & ex_valid & ex_set_flags & ~flush.
  - FSM states IDLE and WAIT:
    - IDLE to WAIT when cond_stall & ~stall.
    - WAIT to IDLE on acc or flush.
    - In WAIT, ID holds cond_valid/cond. The request is accepted the next cycle using the freshly written flags_q. This adds one bubble per back-to-back flag-set/branch pair.

Test Plan:
- Reset then flag write: assert reset for 2 cycles, then ex_valid=1, ex_set_flags=1, N=0, Z=1, C=1, V=0 -> flags_q=4'b0110 after one edge; flags_q stays 4'b0110 when ex_set_flags=0 next.
- Condition table: flags_q=4'b1000; apply cond 0..F one per cycle -> cond_taken at t+1 = 0,1,0,1,1,0,0,1,0,1,0,1,0,1,1,1 with cond_resolved=1 each cycle.
- Back-to-back SUBS/B.EQ: flags_q=0; same cycle flag_wr with Z=1 and cond=0.
  - Bypass: cond_resolved=1, cond_taken=1 next cycle, cond_stall=0.
  - No bypass: cond_stall=1 for 1 cycle, then resolved taken one cycle later.
- Stall/flush: stall=1 with flag_wr inputs and cond_valid -> flags_q unchanged, cond_resolved=0. flush=1 with ex_set_flags=1, Z=1 -> flags_q unchanged, no resolution.
- Counter saturation with CNT_W=4: 20 consecutive taken cond=E requests -> taken_cnt reaches 4'hF and holds.
- Mid-operation reset: reset=1 while in WAIT (no-bypass build) with cond_valid=1 -> next cycle IDLE, all outputs at reset values, cond_stall=0.

Source files
------------

// File: rtl/flag_cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : flag_cond_unit
// Purpose  : Consumer end of the ALU flag interface. Holds the architectural
//            NZCV register, resolves ID-stage B.cond requests against it one
//            cycle after acceptance, and counts taken conditional branches.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            ex_valid/ex_set_flags - EX instruction valid / writes NZCV
//            negative..overflow    - ALU flags from EX
//            stall, flush          - pipeline freeze / squash of ID and EX
//            cond_valid, cond      - ID B.cond request and A64 condition code
//            flags_q               - architectural {N,Z,C,V}
//            cond_resolved/taken   - registered resolution result
//            cond_stall            - combinational hold request to ID
//            taken_cnt             - saturating taken-branch count
// Config   : FLAG_BYPASS_EN - when defined, an EX flag write is forwarded to
//            the same-cycle branch instead of stalling ID for one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module flag_cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_set_flags,
  input  logic             negative,
  input  logic             zero,
  input  logic             carry_out,
  input  logic             overflow,
  input  logic             stall,
  input  logic             flush,
  input  logic             cond_valid,
  input  logic [3:0]       cond,
  output logic [3:0]       flags_q,
  output logic             cond_resolved,
  output logic             cond_taken,
  output logic             cond_stall,
  output logic [CNT_W-1:0] taken_cnt
);

  logic [3:0]       flags_d;
  logic             cond_resolved_q, cond_resolved_d;
  logic             cond_taken_q, cond_taken_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic [3:0]       w_alu_flags;
  logic [3:0]       w_eff;
  logic             w_flag_wr;
  logic             w_acc;

  assign w_alu_flags = {negative, zero, carry_out, overflow};
  assign w_flag_wr   = ex_valid & ex_set_flags & ~stall & ~flush;
  assign w_acc       = cond_valid & ~cond_stall & ~stall & ~flush;

  // A64 condition evaluation, flags ordered {N,Z,C,V}.
  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    logic r;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'h0:    r = z;
      4'h1:    r = ~z;
      4'h2:    r = cy;
      4'h3:    r = ~cy;
      4'h4:    r = n;
      4'h5:    r = ~n;
      4'h6:    r = v;
      4'h7:    r = ~v;
      4'h8:    r = cy & ~z;
      4'h9:    r = ~(cy & ~z);
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = ~z & (n == v);
      4'hD:    r = ~(~z & (n == v));
      default: r = 1'b1;
    endcase
    return r;
  endfunction

`ifdef FLAG_BYPASS_EN
  // The older EX instruction's flags are forwarded straight into the branch.
  assign w_eff = w_flag_wr ? w_alu_flags : flags_q;

  always_comb begin
    cond_stall = 1'b0;
  end
`else
  // Without forwarding, a branch behind a flag-setting EX instruction waits
  // one cycle and is then resolved from the freshly written flags_q.
  localparam logic [0:0] C_IDLE = 1'b0;
  localparam logic [0:0] C_WAIT = 1'b1;

  logic [0:0] state_q, state_d;

  assign w_eff = flags_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= C_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush takes priority over stall.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = C_IDLE;
    end else if (!stall) begin
      case (state_q)
        C_IDLE:  if (cond_stall) state_d = C_WAIT;
        C_WAIT:  if (w_acc)      state_d = C_IDLE;
        default: state_d = C_IDLE;
      endcase
    end
  end

  // Output logic: hold ID while a flag write is in flight ahead of it.
  always_comb begin
    cond_stall = ~reset & cond_valid & ex_valid & ex_set_flags & ~flush;
  end
`endif

  always_comb begin
    flags_d         = w_flag_wr ? w_alu_flags : flags_q;
    cond_resolved_d = w_acc;
    cond_taken_d    = w_acc & eval_cond(cond, w_eff);
    taken_cnt_d     = taken_cnt_q;
    if (cond_resolved_q && cond_taken_q && !stall && !(&taken_cnt_q)) begin
      taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q         <= 4'b0000;
      cond_resolved_q <= 1'b0;
      cond_taken_q    <= 1'b0;
      taken_cnt_q     <= '0;
    end else begin
      flags_q         <= flags_d;
      cond_resolved_q <= cond_resolved_d;
      cond_taken_q    <= cond_taken_d;
      taken_cnt_q     <= taken_cnt_d;
    end
  end

  assign cond_resolved = cond_resolved_q;
  assign cond_taken    = cond_taken_q;
  assign taken_cnt     = taken_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_flag_cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_flag_cond_unit
// Purpose  : Self-checking bench for flag_cond_unit (counter width 4 so that
//            saturation is reachable). Directed scenarios followed by random
//            traffic, all compared against a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flag_cond_unit;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             ex_valid, ex_set_flags;
  logic             negative, zero, carry_out, overflow;
  logic             stall, flush;
  logic             cond_valid;
  logic [3:0]       cond;
  logic [3:0]       flags_q;
  logic             cond_resolved, cond_taken, cond_stall;
  logic [CNT_W-1:0] taken_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [3:0]       m_flags;
  logic             m_res, m_taken;
  logic [CNT_W-1:0] m_cnt;

  flag_cond_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_set_flags(ex_set_flags),
    .negative(negative), .zero(zero), .carry_out(carry_out), .overflow(overflow),
    .stall(stall), .flush(flush), .cond_valid(cond_valid), .cond(cond),
    .flags_q(flags_q), .cond_resolved(cond_resolved), .cond_taken(cond_taken),
    .cond_stall(cond_stall), .taken_cnt(taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A64 rule: pairs of codes share a base predicate, odd code inverts it,
  // and the last pair (AL/NV) is always true.
  function automatic logic ref_eval(input logic [3:0] c, input logic [3:0] f);
    logic base;
    case (c[3:1])
      3'd0:    base = f[2];
      3'd1:    base = f[1];
      3'd2:    base = f[3];
      3'd3:    base = f[0];
      3'd4:    base = f[1] && !f[2];
      3'd5:    base = (f[3] == f[0]);
      3'd6:    base = !f[2] && (f[3] == f[0]);
      default: base = 1'b1;
    endcase
    if (c[3:1] == 3'd7) return 1'b1;
    return base ^ c[0];
  endfunction

  function automatic logic exp_stall();
`ifdef FLAG_BYPASS_EN
    return 1'b0;
`else
    return !reset && cond_valid && ex_valid && ex_set_flags && !flush;
`endif
  endfunction

  // Advance one clock and move the model to its post-edge state.
  task automatic tick();
    logic       fw, acc;
    logic [3:0] alu, eff, nf;
    logic       nres, ntk;
    logic [CNT_W-1:0] nc;
    alu = {negative, zero, carry_out, overflow};
    fw  = ex_valid && ex_set_flags && !stall && !flush;
`ifdef FLAG_BYPASS_EN
    eff = fw ? alu : m_flags;
`else
    eff = m_flags;
`endif
    acc  = cond_valid && !exp_stall() && !stall && !flush;
    nf   = fw ? alu : m_flags;
    nres = acc;
    ntk  = acc && ref_eval(cond, eff);
    nc   = m_cnt;
    if (m_res && m_taken && !stall && int'(m_cnt) < CNT_MAX) nc = m_cnt + 1'b1;
    if (reset) begin
      nf = 4'b0; nres = 1'b0; ntk = 1'b0; nc = '0;
    end
    @(posedge clk);
    #1;
    m_flags = nf; m_res = nres; m_taken = ntk; m_cnt = nc;
  endtask

  task automatic set_idle();
    reset = 1'b0; ex_valid = 1'b0; ex_set_flags = 1'b0;
    {negative, zero, carry_out, overflow} = 4'b0;
    stall = 1'b0; flush = 1'b0; cond_valid = 1'b0; cond = 4'h0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b1; ex_valid = 1'b1; ex_set_flags = 1'b1; cond_valid = 1'b1;
    tick();
    #1;
    n_checks++; if (cond_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", cond_stall); end
    tick();
    n_checks++; if (flags_q !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got=%b exp=0000", flags_q); end
    n_checks++; if (cond_resolved !== 1'b0 || cond_taken !== 1'b0) begin n_fail++; $display("FAIL reset_res got=%b%b exp=00", cond_resolved, cond_taken); end
    n_checks++; if (taken_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", taken_cnt); end
  endtask

  task automatic test_flag_write();
    set_idle();
    ex_valid = 1'b1; ex_set_flags = 1'b1;
    {negative, zero, carry_out, overflow} = 4'b0110;
    tick();
    n_checks++; if (flags_q !== 4'b0110) begin n_fail++; $display("FAIL flag_write got=%b exp=0110", flags_q); end
    ex_set_flags = 1'b0;
    {negative, zero, carry_out, overflow} = 4'($urandom) | 4'b1001;
    tick();
    n_checks++; if (flags_q !== 4'b0110) begin n_fail++; $display("FAIL flag_hold got=%b exp=0110", flags_q); end
  endtask

  task automatic test_cond_table();
    logic [15:0] tbl;
    tbl = 16'b1110_1010_1001_1010;
    set_idle();
    ex_valid = 1'b1; ex_set_flags = 1'b1;
    {negative, zero, carry_out, overflow} = 4'b1000;
    tick();
    set_idle();
    for (int i = 0; i < 16; i++) begin
      cond_valid = 1'b1; cond = 4'(i);
      tick();
      n_checks++; if (cond_resolved !== 1'b1) begin n_fail++; $display("FAIL table_res cond=%0d got=%b exp=1", i, cond_resolved); end
      n_checks++; if (cond_taken !== tbl[i]) begin n_fail++; $display("FAIL table_taken cond=%0d got=%b exp=%b", i, cond_taken, tbl[i]); end
      n_checks++; if (taken_cnt !== m_cnt) begin n_fail++; $display("FAIL table_cnt cond=%0d got=%0d exp=%0d", i, taken_cnt, m_cnt); end
    end
    set_idle();
    tick();
  endtask

  task automatic test_back_to_back();
    set_idle();
    ex_valid = 1'b1; ex_set_flags = 1'b1;
    tick();
    ex_valid = 1'b1; ex_set_flags = 1'b1; zero = 1'b1;
    cond_valid = 1'b1; cond = 4'h0;
    #1;
`ifdef FLAG_BYPASS_EN
    n_checks++; if (cond_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall got=%b exp=0", cond_stall); end
    tick();
    n_checks++; if (cond_resolved !== 1'b1 || cond_taken !== 1'b1) begin n_fail++; $display("FAIL b2b_bypass got=%b%b exp=11", cond_resolved, cond_taken); end
`else
    n_checks++; if (cond_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall got=%b exp=1", cond_stall); end
    tick();
    n_checks++; if (cond_resolved !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble got=%b exp=0", cond_resolved); end
    ex_valid = 1'b0; ex_set_flags = 1'b0; zero = 1'b0;
    #1;
    n_checks++; if (cond_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_release got=%b exp=0", cond_stall); end
    tick();
    n_checks++; if (cond_resolved !== 1'b1 || cond_taken !== 1'b1) begin n_fail++; $display("FAIL b2b_wait_res got=%b%b exp=11", cond_resolved, cond_taken); end
`endif
    n_checks++; if (flags_q !== 4'b0100) begin n_fail++; $display("FAIL b2b_flags got=%b exp=0100", flags_q); end
    set_idle();
    tick();
  endtask

  task automatic test_stall_flush();
    logic [3:0]       saved;
    logic [CNT_W-1:0] c0;
    set_idle();
    cond_valid = 1'b1; cond = 4'hE;
    tick();
    saved = flags_q;
    c0 = m_cnt;
    stall = 1'b1; ex_valid = 1'b1; ex_set_flags = 1'b1;
    {negative, zero, carry_out, overflow} = ~saved;
    tick();
    n_checks++; if (flags_q !== saved) begin n_fail++; $display("FAIL stall_flags got=%b exp=%b", flags_q, saved); end
    n_checks++; if (cond_resolved !== 1'b0) begin n_fail++; $display("FAIL stall_res got=%b exp=0", cond_resolved); end
    n_checks++; if (taken_cnt !== c0) begin n_fail++; $display("FAIL stall_cnt got=%0d exp=%0d", taken_cnt, c0); end
    stall = 1'b0; flush = 1'b1;
    {negative, zero, carry_out, overflow} = 4'b1111;
    tick();
    n_checks++; if (flags_q !== saved) begin n_fail++; $display("FAIL flush_flags got=%b exp=%b", flags_q, saved); end
    n_checks++; if (cond_resolved !== 1'b0) begin n_fail++; $display("FAIL flush_res got=%b exp=0", cond_resolved); end
    set_idle();
    tick();
  endtask

  task automatic test_saturation();
    set_idle();
    for (int i = 0; i < 20; i++) begin
      cond_valid = 1'b1; cond = 4'hE;
      tick();
      n_checks++; if (taken_cnt !== m_cnt) begin n_fail++; $display("FAIL sat_step i=%0d got=%0d exp=%0d", i, taken_cnt, m_cnt); end
    end
    set_idle();
    tick();
    tick();
    n_checks++; if (taken_cnt !== {CNT_W{1'b1}}) begin n_fail++; $display("FAIL sat_hold got=%0d exp=%0d", taken_cnt, CNT_MAX); end
  endtask

  task automatic test_mid_reset();
    set_idle();
    ex_valid = 1'b1; ex_set_flags = 1'b1; zero = 1'b1;
    cond_valid = 1'b1; cond = 4'hE;
    tick();
    reset = 1'b1;
    #1;
    n_checks++; if (cond_stall !== 1'b0) begin n_fail++; $display("FAIL mreset_stall got=%b exp=0", cond_stall); end
    tick();
    n_checks++; if (flags_q !== 4'b0 || cond_resolved !== 1'b0 || cond_taken !== 1'b0 || taken_cnt !== '0) begin
      n_fail++; $display("FAIL mreset_outs flags=%b res=%b tk=%b cnt=%0d exp=all zero", flags_q, cond_resolved, cond_taken, taken_cnt);
    end
    reset = 1'b0; ex_valid = 1'b0; ex_set_flags = 1'b0;
    #1;
    n_checks++; if (cond_stall !== 1'b0) begin n_fail++; $display("FAIL mreset_idle_stall got=%b exp=0", cond_stall); end
    tick();
    n_checks++; if (cond_resolved !== 1'b1 || cond_taken !== 1'b1) begin n_fail++; $display("FAIL mreset_accept got=%b%b exp=11", cond_resolved, cond_taken); end
    set_idle();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      reset        = ($urandom_range(0, 49) == 0);
      ex_valid     = $urandom_range(0, 1) == 1;
      ex_set_flags = $urandom_range(0, 1) == 1;
      {negative, zero, carry_out, overflow} = 4'($urandom);
      stall        = ($urandom_range(0, 5) == 0);
      flush        = ($urandom_range(0, 7) == 0);
      cond_valid   = $urandom_range(0, 1) == 1;
      cond         = 4'($urandom);
      #1;
      n_checks++; if (cond_stall !== exp_stall()) begin n_fail++; $display("FAIL rnd_stall i=%0d got=%b exp=%b", i, cond_stall, exp_stall()); end
      tick();
      n_checks++; if (flags_q !== m_flags) begin n_fail++; $display("FAIL rnd_flags i=%0d got=%b exp=%b", i, flags_q, m_flags); end
      n_checks++; if (cond_resolved !== m_res) begin n_fail++; $display("FAIL rnd_res i=%0d got=%b exp=%b", i, cond_resolved, m_res); end
      n_checks++; if (cond_taken !== m_taken) begin n_fail++; $display("FAIL rnd_taken i=%0d got=%b exp=%b", i, cond_taken, m_taken); end
      n_checks++; if (taken_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, taken_cnt, m_cnt); end
    end
  endtask

  initial begin
    m_flags = 4'b0; m_res = 1'b0; m_taken = 1'b0; m_cnt = '0;
    set_idle();
    reset = 1'b1;
    test_reset();
    test_flag_write();
    test_cond_table();
    test_back_to_back();
    test_stall_flush();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
